// File: rtl/ysyx_23060124_rf_wb_sched.sv
// Register-file write-back scheduler and issue scoreboard for RV32E.
// Optional same-cycle forwarding is enabled by defining RF_SCHED_BYPASS_EN.
module ysyx_23060124_rf_wb_sched #(
  parameter int NREG   = 16,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_wen,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [4:0]        pend_cnt,
  output logic              err_unexp
);

  localparam int IDX_W = $clog2(NREG);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e            rr_last;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            grant_alu;
  logic            grant_lsu;
  logic            conflict;
  logic            hazard;
  logic            unexp;

  // x0 and addresses beyond the RV32E file map to an empty vector, so they are never tracked.
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] r);
    logic [NREG-1:0] v;
    v = '0;
    if (r != '0 && int'(r) < NREG) v[r[IDX_W-1:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic is_pend(input logic [NREG-1:0] vec, input logic [ADDR_W-1:0] r);
    return |(vec & onehot(r));
  endfunction

  function automatic logic [4:0] popcnt(input logic [NREG-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  // LSU wins a conflict whenever the ALU took the previous one.
  assign conflict  = alu_valid && lsu_valid;
  assign grant_lsu = reset && lsu_valid && (!alu_valid || rr_last == SRC_ALU);
  assign grant_alu = reset && alu_valid && !grant_lsu;
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    rf_waddr = alu_rd;
    rf_wdata = alu_data;
    if (grant_lsu) begin
      rf_waddr = lsu_rd;
      rf_wdata = lsu_data;
    end
  end

  assign rf_wen  = (grant_alu || grant_lsu) && rf_waddr != '0;
  assign clr_vec = rf_wen ? onehot(rf_waddr) : '0;
  assign unexp   = rf_wen && !is_pend(pend, rf_waddr);

`ifdef RF_SCHED_BYPASS_EN
  // The register retiring this cycle is visible through the forward path.
  assign pend_eff = pend & ~clr_vec;
  assign fwd1_hit = rf_wen && rf_waddr == iss_rs1;
  assign fwd2_hit = rf_wen && rf_waddr == iss_rs2;
  assign fwd_data = rf_wdata;
`else
  assign pend_eff = pend;
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd_data = '0;
`endif

  assign hazard    = is_pend(pend_eff, iss_rs1) || is_pend(pend_eff, iss_rs2) ||
                     (iss_wen && is_pend(pend_eff, iss_rd));
  assign iss_ready = reset && !hazard;

  // A set in the same cycle as a clear of that register keeps it pending.
  assign set_vec   = (iss_valid && iss_ready && iss_wen) ? onehot(iss_rd) : '0;
  assign pend_next = (pend & ~clr_vec) | set_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      pend_cnt  <= '0;
      err_unexp <= 1'b0;
      rr_last   <= SRC_ALU;
    end else begin
      pend     <= pend_next;
      pend_cnt <= popcnt(pend_next);
      if (unexp) err_unexp <= 1'b1;
      if (conflict) rr_last <= grant_lsu ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_rf_wb_sched.sv
// Directed, table-driven bench for the write-back scheduler; builds with or
// without RF_SCHED_BYPASS_EN and adjusts its expectations accordingly.
module tb_ysyx_23060124_rf_wb_sched;

`ifdef RF_SCHED_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clock;
  logic        reset;
  logic        iss_valid, iss_ready, iss_wen;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
  logic [4:0]  pend_cnt;
  logic        err_unexp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ysyx_23060124_rf_wb_sched dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wen(iss_wen),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
    .pend_cnt(pend_cnt), .err_unexp(err_unexp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv, iw;
    logic [4:0]  rd, rs1, rs2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_iss, e_alu, e_lsu, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [4:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input int iv, input int iw, input int rd, input int rs1, input int rs2,
                              input int av, input int ard, input int unsigned ad,
                              input int lv, input int lrd, input int unsigned ld,
                              input int e_iss, input int e_alu, input int e_lsu, input int e_wen,
                              input int e_waddr, input int unsigned e_wdata,
                              input int e_cnt, input int e_err);
    vec_t v;
    v.iv = 1'(iv);  v.iw = 1'(iw);  v.rd = 5'(rd);  v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);
    v.av = 1'(av);  v.ard = 5'(ard);  v.ad = ad;
    v.lv = 1'(lv);  v.lrd = 5'(lrd);  v.ld = ld;
    v.e_iss = 1'(e_iss);  v.e_alu = 1'(e_alu);  v.e_lsu = 1'(e_lsu);  v.e_wen = 1'(e_wen);
    v.e_waddr = 5'(e_waddr);  v.e_wdata = e_wdata;
    v.e_cnt = 5'(e_cnt);  v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic apply_stimulus(input vec_t v);
    iss_valid = v.iv;  iss_wen = v.iw;  iss_rd = v.rd;  iss_rs1 = v.rs1;  iss_rs2 = v.rs2;
    alu_valid = v.av;  alu_rd = v.ard;  alu_data = v.ad;
    lsu_valid = v.lv;  lsu_rd = v.lrd;  lsu_data = v.ld;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check($sformatf("v%0d iss_ready", idx), 32'(iss_ready), 32'(v.e_iss));
    check($sformatf("v%0d alu_ready", idx), 32'(alu_ready), 32'(v.e_alu));
    check($sformatf("v%0d lsu_ready", idx), 32'(lsu_ready), 32'(v.e_lsu));
    check($sformatf("v%0d rf_wen", idx), 32'(rf_wen), 32'(v.e_wen));
    if (v.e_wen) check($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr), 32'(v.e_waddr));
    if (v.e_alu || v.e_lsu) check($sformatf("v%0d rf_wdata", idx), rf_wdata, v.e_wdata);
  endtask

  task automatic idle_inputs();
    iss_valid = 0;  iss_wen = 0;  iss_rd = 0;  iss_rs1 = 0;  iss_rs2 = 0;
    alu_valid = 0;  alu_rd = 0;  alu_data = 0;
    lsu_valid = 0;  lsu_rd = 0;  lsu_data = 0;
  endtask

  initial begin
    //        iv iw rd s1 s2  av ard ad       lv lrd ld      iss alu lsu wen wa wdata    cnt err
    vecs[0]  = mk(1, 1, 5, 0, 0, 0, 0, 0,        0, 0, 0,       1,  0,  0,  0,  0, 0,        1,  0);
    vecs[1]  = mk(1, 0, 0, 5, 0, 0, 0, 0,        0, 0, 0,       0,  0,  0,  0,  0, 0,        1,  0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 5, 'h1234,   0, 0, 0,       1,  1,  0,  1,  5, 'h1234,   0,  0);
    vecs[3]  = mk(1, 0, 0, 5, 0, 0, 0, 0,        0, 0, 0,       1,  0,  0,  0,  0, 0,        0,  0);
    vecs[4]  = mk(1, 1, 7, 0, 0, 0, 0, 0,        0, 0, 0,       1,  0,  0,  0,  0, 0,        1,  0);
    vecs[5]  = mk(1, 1, 7, 0, 0, 0, 0, 0,        0, 0, 0,       0,  0,  0,  0,  0, 0,        1,  0);
    vecs[6]  = mk(1, 1, 7, 0, 0, 1, 7, 'h77,     0, 0, 0,       BYP, 1, 0,  1,  7, 'h77,     BYP, 0);
    vecs[7]  = mk(1, 1, 7, 0, 0, 0, 0, 0,        0, 0, 0,       1 - BYP, 0, 0, 0, 0, 0,      1,  0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 7, 'h700,   1,  0,  1,  1,  7, 'h700,    0,  0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 'hA0,     1, 0, 'hB0,    1,  0,  1,  0,  0, 'hB0,     0,  0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 'hA1,     1, 0, 'hB1,    1,  1,  0,  0,  0, 'hA1,     0,  0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 'hA2,     1, 0, 'hB2,    1,  0,  1,  0,  0, 'hB2,     0,  0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 'hA3,     1, 0, 'hB3,    1,  1,  0,  0,  0, 'hA3,     0,  0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,        1, 3, 'h33,    1,  0,  1,  1,  3, 'h33,     0,  1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,       1,  0,  0,  0,  0, 0,        0,  1);
    vecs[15] = mk(1, 1, 9, 0, 0, 1, 0, 'h5A,     0, 0, 0,       1,  1,  0,  0,  0, 'h5A,     1,  1);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 9, 'h99,     1, 0, 'hC0,    1,  0,  1,  0,  0, 'hC0,     1,  1);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 9, 'h99,     0, 0, 0,       1,  1,  0,  1,  9, 'h99,     0,  1);

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("reset pend_cnt", 32'(pend_cnt), 32'd0);
    check("reset err_unexp", 32'(err_unexp), 32'd0);
    check("reset iss_ready", 32'(iss_ready), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      apply_stimulus(vecs[i]);
      #2;
      check_output(i, vecs[i]);
      @(posedge clock);
      #1;
      check($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d err_unexp", i), 32'(err_unexp), 32'(vecs[i].e_err));
    end

    // Fill x1..x3, then pull reset in the middle of a cycle with both requesters active.
    for (int r = 1; r <= 3; r++) begin
      @(negedge clock);
      idle_inputs();
      iss_valid = 1;  iss_wen = 1;  iss_rd = 5'(r);
      @(posedge clock);
    end
    #1;
    check("fill pend_cnt", 32'(pend_cnt), 32'd3);
    @(negedge clock);
    idle_inputs();
    iss_valid = 1;
    alu_valid = 1;  alu_rd = 1;  alu_data = 32'h11;
    lsu_valid = 1;  lsu_rd = 2;  lsu_data = 32'h22;
    #2;
    reset = 1'b0;
    #1;
    check("async pend_cnt", 32'(pend_cnt), 32'd0);
    check("async err_unexp", 32'(err_unexp), 32'd0);
    check("async iss_ready", 32'(iss_ready), 32'd0);
    check("async alu_ready", 32'(alu_ready), 32'd0);
    check("async lsu_ready", 32'(lsu_ready), 32'd0);
    check("async rf_wen", 32'(rf_wen), 32'd0);
    @(posedge clock);
    #1;
    check("held pend_cnt", 32'(pend_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    alu_rd = 0;
    lsu_rd = 0;
    #2;
    check("post-reset lsu wins", 32'(lsu_ready), 32'd1);
    check("post-reset alu loses", 32'(alu_ready), 32'd0);
    check("post-reset rf_wdata", rf_wdata, 32'h22);
    @(negedge clock);
    idle_inputs();
    iss_valid = 1;  iss_rs1 = 1;
    #2;
    check("post-reset rs1=1 ready", 32'(iss_ready), 32'd1);

    // Grant a write to x4 while a reader of x4 is waiting at issue.
    @(negedge clock);
    idle_inputs();
    iss_valid = 1;  iss_wen = 1;  iss_rd = 4;
    @(posedge clock);
    #1;
    check("x4 pend_cnt", 32'(pend_cnt), 32'd1);
    @(negedge clock);
    idle_inputs();
    iss_valid = 1;  iss_rs2 = 4;
    alu_valid = 1;  alu_rd = 4;  alu_data = 32'hDEADBEEF;
    #2;
    check("byp iss_ready", 32'(iss_ready), 32'(BYP));
    check("byp fwd2_hit", 32'(fwd2_hit), 32'(BYP));
    check("byp fwd1_hit", 32'(fwd1_hit), 32'd0);
    check("byp fwd_data", fwd_data, (BYP != 0) ? 32'hDEADBEEF : 32'h0);
    check("byp rf_wen", 32'(rf_wen), 32'd1);
    @(posedge clock);
    #1;
    check("byp pend_cnt", 32'(pend_cnt), 32'd0);
    @(negedge clock);
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
